// File: rtl/erx_protocol_if.sv
// Receive-side bus bundle: IO-stage beats in, erx core packets out, plus pushback and status.
// Latency: none, this is wiring only.
// Backpressure: erx_wait stalls the core side; rx_wr_wait/rx_rd_wait push back on the link side.
interface erx_protocol_if #(
    parameter int PW    = 104,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          rx_access;
    logic          rx_burst;
    logic [PW-1:0] rx_packet;
    logic          erx_wait;
    logic          erx_access;
    logic [PW-1:0] erx_packet;
    logic          rx_wr_wait;
    logic          rx_rd_wait;
    logic [CW-1:0] erx_fifo_count;
    logic          erx_overflow;
    logic          erx_burst_err;

    // Receive block side
    modport slave (
        input  rx_access, rx_burst, rx_packet, erx_wait,
        output erx_access, erx_packet, rx_wr_wait, rx_rd_wait,
               erx_fifo_count, erx_overflow, erx_burst_err
    );

    // Stimulus / surrounding logic side
    modport master (
        output rx_access, rx_burst, rx_packet, erx_wait,
        input  erx_access, erx_packet, rx_wr_wait, rx_rd_wait,
               erx_fifo_count, erx_overflow, erx_burst_err
    );
endinterface

// File: rtl/erx_protocol.sv
// Expands elink burst beats into fully addressed packets and queues them for the erx core.
// Latency: 1 cycle from rx_access to erx_access when the FIFO is empty.
// Backpressure: erx_wait holds the head; pushback is registered at count >= DEPTH-MARGIN; full FIFO drops.
module erx_protocol #(
    parameter int PW     = 104,
    parameter int DEPTH  = 4,
    parameter int MARGIN = 2
) (
    input  logic           rx_lclk_div4,
    input  logic           erx_reset,
    erx_protocol_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] HI_WM    = (AW + 1)'(DEPTH - MARGIN);

    logic [PW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   count;
    logic          not_empty;
    logic          full;
    logic          pop;
    logic          push;

    logic          hdr_valid;
    logic          hdr_write;
    logic [1:0]    hdr_datamode;
    logic [3:0]    hdr_ctrlmode;
    logic [31:0]   hdr_dstaddr;

    logic [31:0]   next_dstaddr;
    logic          is_cont;
    logic [PW-1:0] fmt_packet;

    // Burst continuation beats inherit the header fields and step the address by 8
    always_comb begin
        next_dstaddr = hdr_dstaddr + 32'd8;
        is_cont      = bus.rx_burst & hdr_valid;
        fmt_packet   = bus.rx_packet;
        if (is_cont) begin
            fmt_packet = {bus.rx_packet[PW-1:40], next_dstaddr,
                          hdr_ctrlmode, hdr_datamode, hdr_write, 1'b1};
        end
    end

    // Occupancy from pointers with wrap bit; a push into a full FIFO survives only if the head pops
    always_comb begin
        count     = wr_ptr - rd_ptr;
        not_empty = (count != '0);
        full      = (count == FULL_CNT);
        pop       = not_empty & ~bus.erx_wait;
        push      = bus.rx_access & (~full | pop);
    end

    assign bus.erx_access     = not_empty;
    assign bus.erx_packet     = not_empty ? mem[rd_ptr[AW-1:0]] : '0;
    assign bus.erx_fifo_count = count;

    // Storage array; contents beyond the pointers are never observed so no reset is needed
    always_ff @(posedge rx_lclk_div4) begin
        if (push && !erx_reset) begin
            mem[wr_ptr[AW-1:0]] <= fmt_packet;
        end
    end

    // Pointers, header tracking, sticky errors and registered pushback
    always_ff @(posedge rx_lclk_div4) begin
        if (erx_reset) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            hdr_valid         <= 1'b0;
            hdr_write         <= 1'b0;
            hdr_datamode      <= '0;
            hdr_ctrlmode      <= '0;
            hdr_dstaddr       <= '0;
            bus.erx_overflow  <= 1'b0;
            bus.erx_burst_err <= 1'b0;
            bus.rx_wr_wait    <= 1'b0;
            bus.rx_rd_wait    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Dropped beats still advance the header so later beats stay aligned
            if (bus.rx_access) begin
                hdr_valid    <= 1'b1;
                hdr_write    <= fmt_packet[1];
                hdr_datamode <= fmt_packet[3:2];
                hdr_ctrlmode <= fmt_packet[7:4];
                hdr_dstaddr  <= fmt_packet[39:8];
                if (!push) begin
                    bus.erx_overflow <= 1'b1;
                end
                if (bus.rx_burst && !hdr_valid) begin
                    bus.erx_burst_err <= 1'b1;
                end
            end
            bus.rx_wr_wait <= (count >= HI_WM);
            bus.rx_rd_wait <= (count >= HI_WM) | bus.erx_wait;
        end
    end
endmodule

// File: tb/tb_erx_protocol.sv
// Directed bench for erx_protocol: reset, single beat, burst expansion, address wrap,
// backpressure/overflow, full with simultaneous push+pop, orphan burst and mid-drain reset.
// Inputs change 1 time unit after each posedge; outputs are checked at the same point.
module tb_erx_protocol;
    localparam int PW = 104;
    localparam int DEPTH = 4;
    localparam int MARGIN = 2;

    logic clk = 1'b0;
    logic erx_reset;
    int   checks = 0;
    int   failures = 0;

    erx_protocol_if #(.PW(PW), .DEPTH(DEPTH)) bus ();

    erx_protocol #(.PW(PW), .DEPTH(DEPTH), .MARGIN(MARGIN)) dut (
        .rx_lclk_div4 (clk),
        .erx_reset    (erx_reset),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mk(input logic w, input logic [1:0] dm, input logic [3:0] cm,
                                         input logic [31:0] dst, input logic [31:0] dat,
                                         input logic [31:0] src);
        return {src, dat, dst, cm, dm, w, 1'b1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.rx_access = 1'b0;
        bus.rx_burst  = 1'b0;
        bus.rx_packet = '0;
    endtask

    task automatic do_reset();
        erx_reset = 1'b1;
        tick();
        erx_reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_in();
        bus.erx_wait = 1'b0;
        do_reset();
        checks++;
        if (bus.erx_access !== 1'b0) begin failures++; $display("FAIL reset_access got=%b exp=0", bus.erx_access); end
        checks++;
        if (bus.erx_fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.erx_fifo_count); end
        checks++;
        if (bus.erx_packet !== '0) begin failures++; $display("FAIL reset_packet got=%h exp=0", bus.erx_packet); end
        checks++;
        if ({bus.rx_wr_wait, bus.rx_rd_wait, bus.erx_overflow, bus.erx_burst_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {bus.rx_wr_wait, bus.rx_rd_wait, bus.erx_overflow, bus.erx_burst_err});
        end
    endtask

    task automatic test_orphan_burst();
        logic [PW-1:0] p;
        p = mk(1'b1, 2'd1, 4'h3, 32'h0000_4000, 32'hCAFE_0001, 32'h0000_0077);
        bus.rx_access = 1'b1;
        bus.rx_burst  = 1'b1;
        bus.rx_packet = p;
        tick();
        idle_in();
        checks++;
        if (bus.erx_packet !== p) begin failures++; $display("FAIL orphan_packet got=%h exp=%h", bus.erx_packet, p); end
        checks++;
        if (bus.erx_burst_err !== 1'b1) begin failures++; $display("FAIL orphan_err got=%b exp=1", bus.erx_burst_err); end
        tick();
        checks++;
        if (bus.erx_fifo_count !== 3'd0) begin failures++; $display("FAIL orphan_drain got=%0d exp=0", bus.erx_fifo_count); end
    endtask

    task automatic test_single();
        logic [PW-1:0] p;
        do_reset();
        p = mk(1'b1, 2'd2, 4'h0, 32'h8000_0010, 32'h1234_5678, 32'h0000_00AB);
        bus.rx_access = 1'b1;
        bus.rx_packet = p;
        tick();
        idle_in();
        checks++;
        if (bus.erx_access !== 1'b1) begin failures++; $display("FAIL single_access got=%b exp=1", bus.erx_access); end
        checks++;
        if (bus.erx_packet !== p) begin failures++; $display("FAIL single_packet got=%h exp=%h", bus.erx_packet, p); end
        checks++;
        if (bus.erx_burst_err !== 1'b0) begin failures++; $display("FAIL single_err_cleared got=%b exp=0", bus.erx_burst_err); end
        tick();
        checks++;
        if (bus.erx_access !== 1'b0 || bus.erx_fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL single_done got=%b/%0d exp=0/0", bus.erx_access, bus.erx_fifo_count);
        end
    endtask

    task automatic test_burst();
        logic [PW-1:0] exp_q [4];
        bus.erx_wait = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.rx_access = 1'b1;
            bus.rx_burst  = (k != 0);
            if (k == 0) bus.rx_packet = mk(1'b1, 2'd2, 4'h5, 32'h0000_1000, 32'hD000_0000, 32'h5000_0000);
            else        bus.rx_packet = mk(1'b0, 2'd0, 4'hA, 32'hDEAD_0000, 32'hD000_0000 + k, 32'h5000_0000 + k);
            exp_q[k] = mk(1'b1, 2'd2, 4'h5, 32'h0000_1000 + 32'(k * 8), 32'hD000_0000 + k, 32'h5000_0000 + k);
            tick();
        end
        idle_in();
        checks++;
        if (bus.erx_fifo_count !== 3'd4) begin failures++; $display("FAIL burst_count got=%0d exp=4", bus.erx_fifo_count); end
        bus.erx_wait = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.erx_packet !== exp_q[k]) begin failures++; $display("FAIL burst_pkt%0d got=%h exp=%h", k, bus.erx_packet, exp_q[k]); end
            tick();
        end
        checks++;
        if (bus.erx_fifo_count !== 3'd0) begin failures++; $display("FAIL burst_drain got=%0d exp=0", bus.erx_fifo_count); end
    endtask

    task automatic test_wrap();
        logic [PW-1:0] e0;
        logic [PW-1:0] e1;
        e0 = mk(1'b0, 2'd1, 4'h3, 32'hFFFF_FFF8, 32'hAAAA_0001, 32'hBBBB_0001);
        e1 = mk(1'b0, 2'd1, 4'h3, 32'h0000_0000, 32'hAAAA_0002, 32'hBBBB_0002);
        bus.erx_wait  = 1'b1;
        bus.rx_access = 1'b1;
        bus.rx_packet = e0;
        tick();
        bus.rx_burst  = 1'b1;
        bus.rx_packet = mk(1'b1, 2'd3, 4'hF, 32'h1234_5678, 32'hAAAA_0002, 32'hBBBB_0002);
        tick();
        idle_in();
        bus.erx_wait = 1'b0;
        checks++;
        if (bus.erx_packet !== e0) begin failures++; $display("FAIL wrap_hdr got=%h exp=%h", bus.erx_packet, e0); end
        tick();
        checks++;
        if (bus.erx_packet !== e1) begin failures++; $display("FAIL wrap_beat got=%h exp=%h", bus.erx_packet, e1); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] p [5];
        do_reset();
        for (int k = 0; k < 5; k++) p[k] = mk(1'b1, 2'd2, 4'h0, 32'h0000_2000 + 32'(k * 16), 32'h7700_0000 + k, 32'h0000_0100);
        bus.erx_wait  = 1'b1;
        bus.rx_access = 1'b1;
        bus.rx_packet = p[0];
        tick();
        checks++;
        if (bus.erx_fifo_count !== 3'd1 || bus.rx_wr_wait !== 1'b0) begin
            failures++; $display("FAIL bp_push1 got=%0d/%b exp=1/0", bus.erx_fifo_count, bus.rx_wr_wait);
        end
        checks++;
        if (bus.rx_rd_wait !== 1'b1) begin failures++; $display("FAIL bp_rd_wait got=%b exp=1", bus.rx_rd_wait); end
        bus.rx_packet = p[1];
        tick();
        checks++;
        if (bus.erx_fifo_count !== 3'd2 || bus.rx_wr_wait !== 1'b0) begin
            failures++; $display("FAIL bp_push2 got=%0d/%b exp=2/0", bus.erx_fifo_count, bus.rx_wr_wait);
        end
        bus.rx_packet = p[2];
        tick();
        checks++;
        if (bus.rx_wr_wait !== 1'b1) begin failures++; $display("FAIL bp_wr_wait_rise got=%b exp=1", bus.rx_wr_wait); end
        bus.rx_packet = p[3];
        tick();
        checks++;
        if (bus.erx_overflow !== 1'b0) begin failures++; $display("FAIL bp_no_early_ovf got=%b exp=0", bus.erx_overflow); end
        bus.rx_packet = p[4];
        tick();
        checks++;
        if (bus.erx_fifo_count !== 3'd4 || bus.erx_overflow !== 1'b1) begin
            failures++; $display("FAIL bp_drop got=%0d/%b exp=4/1", bus.erx_fifo_count, bus.erx_overflow);
        end
        idle_in();
        bus.erx_wait = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.erx_packet !== p[k]) begin failures++; $display("FAIL bp_order%0d got=%h exp=%h", k, bus.erx_packet, p[k]); end
            tick();
            if (k == 2) begin
                checks++;
                if (bus.rx_wr_wait !== 1'b1) begin failures++; $display("FAIL bp_wr_wait_lag got=%b exp=1", bus.rx_wr_wait); end
            end
        end
        checks++;
        if (bus.rx_wr_wait !== 1'b0 || bus.erx_fifo_count !== 3'd0) begin
            failures++; $display("FAIL bp_wr_wait_fall got=%b/%0d exp=0/0", bus.rx_wr_wait, bus.erx_fifo_count);
        end
        checks++;
        if (bus.erx_overflow !== 1'b1) begin failures++; $display("FAIL bp_ovf_sticky got=%b exp=1", bus.erx_overflow); end
    endtask

    task automatic test_full_simul();
        logic [PW-1:0] q [5];
        do_reset();
        for (int k = 0; k < 5; k++) q[k] = mk(1'b0, 2'd0, 4'h1, 32'h0000_3000 + 32'(k * 4), 32'h0BAD_0000 + k, 32'h0000_0200);
        bus.erx_wait  = 1'b1;
        bus.rx_access = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.rx_packet = q[k];
            tick();
        end
        bus.erx_wait  = 1'b0;
        bus.rx_packet = q[4];
        tick();
        idle_in();
        checks++;
        if (bus.erx_fifo_count !== 3'd4 || bus.erx_overflow !== 1'b0) begin
            failures++; $display("FAIL full_simul got=%0d/%b exp=4/0", bus.erx_fifo_count, bus.erx_overflow);
        end
        for (int k = 1; k < 5; k++) begin
            checks++;
            if (bus.erx_packet !== q[k]) begin failures++; $display("FAIL full_order%0d got=%h exp=%h", k, bus.erx_packet, q[k]); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [PW-1:0] r;
        bus.erx_wait  = 1'b1;
        bus.rx_access = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.rx_packet = mk(1'b1, 2'd1, 4'h2, 32'h0000_5000 + 32'(k * 8), 32'h0000_1000 + k, 32'h0);
            tick();
        end
        bus.erx_wait = 1'b0;
        idle_in();
        tick();
        checks++;
        if (bus.erx_fifo_count !== 3'd3) begin failures++; $display("FAIL mid_count got=%0d exp=3", bus.erx_fifo_count); end
        erx_reset     = 1'b1;
        bus.rx_access = 1'b1;
        bus.rx_burst  = 1'b1;
        bus.rx_packet = mk(1'b1, 2'd1, 4'h2, 32'h0000_9000, 32'h0000_2000, 32'h0);
        tick();
        erx_reset = 1'b0;
        idle_in();
        checks++;
        if (bus.erx_access !== 1'b0 || bus.erx_fifo_count !== 3'd0) begin
            failures++; $display("FAIL mid_reset got=%b/%0d exp=0/0", bus.erx_access, bus.erx_fifo_count);
        end
        checks++;
        if ({bus.rx_wr_wait, bus.rx_rd_wait, bus.erx_overflow, bus.erx_burst_err} !== 4'b0000) begin
            failures++; $display("FAIL mid_flags got=%b exp=0000", {bus.rx_wr_wait, bus.rx_rd_wait, bus.erx_overflow, bus.erx_burst_err});
        end
        r = mk(1'b0, 2'd3, 4'h9, 32'h0000_0040, 32'h0000_3333, 32'h0000_4444);
        bus.rx_access = 1'b1;
        bus.rx_burst  = 1'b1;
        bus.rx_packet = r;
        tick();
        idle_in();
        checks++;
        if (bus.erx_packet !== r || bus.erx_burst_err !== 1'b1) begin
            failures++; $display("FAIL mid_hdr_cleared got=%h/%b exp=%h/1", bus.erx_packet, bus.erx_burst_err, r);
        end
        tick();
    endtask

    initial begin
        erx_reset = 1'b0;
        bus.erx_wait = 1'b0;
        idle_in();
        test_reset();
        test_orphan_burst();
        test_single();
        test_burst();
        test_wrap();
        test_backpressure();
        test_full_simul();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
